// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Operand/result handshake bundle for serial_adder.
//   master: drives in_valid, a, b, ci, sub, out_ready; receives in_ready,
//           out_valid, h, l (and v).
//   slave : the adder side of the same bundle.
//   Port v is present only when SERIAL_ADDER_OVERFLOW_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic             h;
  logic [WIDTH-1:0] l;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             v;

  modport master (output in_valid, a, b, ci, sub, out_ready,
                  input  in_ready, out_valid, h, l, v);
  modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                  output in_ready, out_valid, h, l, v);
`else
  modport master (output in_valid, a, b, ci, sub, out_ready,
                  input  in_ready, out_valid, h, l);
  modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                  output in_ready, out_valid, h, l);
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per
//   clock with a registered carry between chunks (N = WIDTH/CHUNK cycles).
//   sub=0: {h,l} = a + b + ci.  sub=1: l = a - b - ci, h = borrow out.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if.slave (in_valid/in_ready/a/b/ci/sub,
//          out_valid/out_ready/h/l[/v])
// Options
//   SERIAL_ADDER_OVERFLOW_EN : adds signed-overflow output v.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, l_q;
  logic             carry_q, sub_q, h_q;
  logic             in_ready_q, out_valid_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             v_q;
`endif

  // One CHUNK-wide slice of the ripple adder; top bit is the chunk carry-out.
  logic [CHUNK:0]   sum_d;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    sum_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  end

  // Partial result: previously computed chunks sit top-aligned, so the newest
  // chunk enters at the top and the full word lines up after the last chunk.
  generate
    if (N == 1) begin : g_one
      assign res_d = sum_d[CHUNK-1:0];
    end else begin : g_multi
      logic [WIDTH-CHUNK-1:0] res_q;
      assign res_d = {sum_d[CHUNK-1:0], res_q};
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                 res_q <= '0;
        else if (state_q == RUN) res_q <= res_d[WIDTH-1:CHUNK];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      l_q         <= '0;
      h_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      v_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            // Subtract as a + ~b + 1; a borrow-in cancels the +1.
            a_q        <= bus.a;
            b_q        <= bus.sub ? ~bus.b : bus.b;
            carry_q    <= bus.ci ^ bus.sub;
            sub_q      <= bus.sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= sum_d[CHUNK];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            l_q         <= res_d;
            // Internal carry is an inverted borrow when subtracting.
            h_q         <= sum_d[CHUNK] ^ sub_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // Carry into the MSB is the MSB sum bit with the operand bits removed.
            v_q         <= a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ sum_d[CHUNK-1] ^ sum_d[CHUNK];
`endif
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.l         = l_q;
  assign bus.h         = h_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign bus.v         = v_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: two instances (16/4 and 8/8) driven by one stimulus
// flow and checked every cycle against an arithmetic/handshake model.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(16)) bus0();
  serial_adder_if #(.WIDTH(8))  bus1();

  serial_adder #(.WIDTH(16), .CHUNK(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  serial_adder #(.WIDTH(8),  .CHUNK(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // stimulus
  logic        iv [2];
  logic        ici [2];
  logic        isub [2];
  logic        ordy [2];
  logic [15:0] ia [2];
  logic [15:0] ib [2];
  // observed
  logic        oir [2];
  logic        oov [2];
  logic        oh [2];
  logic [15:0] ol [2];

  assign bus0.in_valid  = iv[0];
  assign bus0.a         = ia[0];
  assign bus0.b         = ib[0];
  assign bus0.ci        = ici[0];
  assign bus0.sub       = isub[0];
  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid  = iv[1];
  assign bus1.a         = ia[1][7:0];
  assign bus1.b         = ib[1][7:0];
  assign bus1.ci        = ici[1];
  assign bus1.sub       = isub[1];
  assign bus1.out_ready = ordy[1];
  assign oir[0] = bus0.in_ready;
  assign oir[1] = bus1.in_ready;
  assign oov[0] = bus0.out_valid;
  assign oov[1] = bus1.out_valid;
  assign oh[0]  = bus0.h;
  assign oh[1]  = bus1.h;
  assign ol[0]  = bus0.l;
  assign ol[1]  = {8'h00, bus1.l};
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf [2];
  assign ovf[0] = bus0.v;
  assign ovf[1] = bus1.v;
`endif

  // literal expectations posted by the stimulus flow, latched at accept
  bit          lit_on [2];
  logic [15:0] lit_l [2];
  logic        lit_h [2];
  logic        lit_v [2];
  int          lit_lat [2];
  int          tmo_cnt = 0;

  // compare-process state
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          tmo_seen = 0;
  bit          m_idle [2];
  bit          m_done [2];
  int          m_wait [2];
  logic [15:0] m_l [2];
  logic        m_h [2];
  logic        m_v [2];
  logic [15:0] p_l [2];
  logic        p_h [2];
  logic        p_v [2];
  int          acc_cyc [2];
  bit          armed [2];
  logic [15:0] c_l [2];
  logic        c_h [2];
  logic        c_v [2];
  int          c_lat [2];

  function automatic int w_of(input int i);  return (i == 0) ? 16 : 8; endfunction
  function automatic int n_of(input int i);  return (i == 0) ? 4 : 1;  endfunction

  // Reference arithmetic in plain integers.
  function automatic void calc(input int w, input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic sub,
                               output logic [15:0] l, output logic h, output logic v);
    longint m, ua, ub, c, s, half, sa, sb, r;
    m    = (longint'(1) << w) - 1;
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    c    = ci ? 1 : 0;
    half = longint'(1) << (w - 1);
    s    = sub ? (ua - ub - c) : (ua + ub + c);
    l    = 16'(s & m);
    h    = sub ? (ua < ub + c) : (((s >> w) & 1) != 0);
    sa   = (ua >= half) ? ua - (m + 1) : ua;
    sb   = (ub >= half) ? ub - (m + 1) : ub;
    r    = sub ? (sa - sb - c) : (sa + sb + c);
    v    = (r < -half) || (r > half - 1);
  endfunction

  task automatic chk(input string nm, input int i, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[dut%0d] @cyc %0d: got 0x%0h, expected 0x%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Single compare process: every falling edge, and right after async reset.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("rst_in_ready", i, oir[i], 1);
        chk("rst_out_valid", i, oov[i], 0);
        chk("rst_l", i, ol[i], 0);
        chk("rst_h", i, oh[i], 0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("rst_v", i, ovf[i], 0);
`endif
        m_idle[i] = 1; m_done[i] = 0; m_wait[i] = 0;
        m_l[i] = '0; m_h[i] = 0; m_v[i] = 0; armed[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", i, oir[i], m_idle[i]);
        chk("out_valid", i, oov[i], m_done[i]);
        chk("l", i, ol[i], m_l[i]);
        chk("h", i, oh[i], m_h[i]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("v", i, ovf[i], m_v[i]);
`endif
        if (armed[i] && oov[i]) begin
          armed[i] = 0;
          chk("lit_latency", i, cyc - acc_cyc[i] - 1, c_lat[i]);
          chk("lit_l", i, ol[i], c_l[i]);
          chk("lit_h", i, oh[i], c_h[i]);
`ifdef SERIAL_ADDER_OVERFLOW_EN
          chk("lit_v", i, ovf[i], c_v[i]);
`endif
        end
        // predict the effect of the coming rising edge
        if (m_idle[i]) begin
          if (iv[i]) begin
            calc(w_of(i), ia[i], ib[i], ici[i], isub[i], p_l[i], p_h[i], p_v[i]);
            m_idle[i] = 0; m_wait[i] = n_of(i); acc_cyc[i] = cyc;
            armed[i] = lit_on[i];
            c_l[i] = lit_l[i]; c_h[i] = lit_h[i]; c_v[i] = lit_v[i]; c_lat[i] = lit_lat[i];
          end
        end else if (m_wait[i] > 0) begin
          m_wait[i]--;
          if (m_wait[i] == 0) begin
            m_done[i] = 1; m_l[i] = p_l[i]; m_h[i] = p_h[i]; m_v[i] = p_v[i];
          end
        end else if (m_done[i] && ordy[i]) begin
          m_done[i] = 0; m_idle[i] = 1;
        end
      end
      if (tmo_cnt != tmo_seen) begin
        chk("handshake_timeout", 0, tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic sub);
    bit acc, r;
    ia[i] = a; ib[i] = b; ici[i] = ci; isub[i] = sub; iv[i] = 1;
    acc = 0;
    for (int k = 0; k < 50 && !acc; k++) begin
      r = oir[i];
      @(posedge clk); #1;
      acc = r;
    end
    iv[i] = 0;
    if (!acc) tmo_cnt++;
  endtask

  task automatic wait_out(input int i);
    int k;
    k = 0;
    while (!oov[i] && k < 50) begin @(posedge clk); #1; k++; end
    if (!oov[i]) tmo_cnt++;
  endtask

  task automatic wait_done(input int i, input int hold);
    ordy[i] = (hold == 0);
    wait_out(i);
    repeat (hold) begin @(posedge clk); #1; end
    ordy[i] = 1;
    @(posedge clk); #1;
  endtask

  task automatic op(input int i, input logic [15:0] a, input logic [15:0] b,
                    input logic ci, input logic sub, input bit lit,
                    input logic [15:0] el, input logic eh, input logic ev,
                    input int lat, input int hold);
    lit_on[i] = lit; lit_l[i] = el; lit_h[i] = eh; lit_v[i] = ev; lit_lat[i] = lat;
    send(i, a, b, ci, sub);
    wait_done(i, hold);
    lit_on[i] = 0;
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(5, 0))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; ici[i] = 0; isub[i] = 0; ordy[i] = 1; ia[i] = '0; ib[i] = '0;
      lit_on[i] = 0; lit_l[i] = '0; lit_h[i] = 0; lit_v[i] = 0; lit_lat[i] = 0;
    end
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // carry ripples through every chunk
    op(0, 16'hFFFF, 16'h0001, 0, 0, 1, 16'h0000, 1, 0, 4, 0);
    // subtraction with and without borrow-in
    op(0, 16'h1234, 16'h1235, 0, 1, 1, 16'hFFFF, 1, 0, 4, 0);
    op(0, 16'h0005, 16'h0002, 1, 1, 1, 16'h0002, 0, 0, 4, 0);

    // backpressure: hold DONE five cycles with a stray in_valid present
    lit_on[0] = 1; lit_l[0] = 16'h1000; lit_h[0] = 0; lit_v[0] = 0; lit_lat[0] = 4;
    ordy[0] = 0;
    send(0, 16'h00FF, 16'h0F01, 0, 0);
    lit_on[0] = 0;
    wait_out(0);
    ia[0] = 16'hDEAD; ib[0] = 16'hBEEF; iv[0] = 1;
    repeat (5) begin @(posedge clk); #1; end
    iv[0] = 0; ordy[0] = 1;
    @(posedge clk); #1;

    // asynchronous reset after two chunks
    send(0, 16'h1234, 16'h1111, 0, 0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #1 rst = 0;
    op(0, 16'h0003, 16'h0004, 1, 0, 1, 16'h0008, 0, 0, 4, 0);

    // signed overflow corners
    op(0, 16'h7FFF, 16'h0001, 0, 0, 1, 16'h8000, 0, 1, 4, 0);
    op(0, 16'h8000, 16'h0001, 0, 1, 1, 16'h7FFF, 0, 1, 4, 0);
    op(0, 16'h0002, 16'h0003, 0, 0, 1, 16'h0005, 0, 0, 4, 0);

    // single-chunk instance
    op(1, 16'h00AA, 16'h0055, 1, 0, 1, 16'h0000, 1, 0, 1, 0);
    op(1, 16'h0010, 16'h0020, 0, 1, 1, 16'h00F0, 1, 0, 1, 2);

    // randomized operations on both instances
    for (int t = 0; t < 160; t++) begin
      int i;
      i = int'($urandom_range(1, 0));
      op(i, pick(), pick(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
         0, 16'h0, 0, 0, 0, int'($urandom_range(3, 0)));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock, with a registered carry between chunks. It sits in the arithmetic library above the single-bit half/full adder cells. It serves datapaths that trade latency for area, and uses valid/ready handshakes on both input and output.

## Interface
- WIDTH, 16, operand and result width; must be a positive multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH. N = WIDTH/CHUNK is the number of compute cycles.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept an operand bundle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- h  output  1  carry-out (add) / borrow-out (sub).
- l  output  WIDTH  result.
- v  output  1  signed overflow; present only with SERIAL_ADDER_OVERFLOW_EN.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a; latch b if sub=0 or ~b if sub=1; carry register = ci ^ sub; chunk counter = 0; → RUN.
- RUN:
  - Each cycle: add the low CHUNK bits of the A/B shift registers plus the carry register.
  - Shift the CHUNK-bit sum into the top of the result register; shift operands right by CHUNK; update the carry register.
  - After chunk N-1: → DONE.
- DONE:
  - out_valid = 1.
  - l = result register.
  - h = final carry ^ sub.
  - On out_valid & out_ready: → IDLE.
- Arithmetic:
  - sub=0: {h,l} = a + b + ci.
  - sub=1: l = (a − b − ci) mod 2^WIDTH; h = 1 iff a < b + ci (unsigned).
- in_ready = 1 only in IDLE. There is no accept during RUN or DONE, and no accept in the same cycle as the output handshake.
- in_valid, a, b, ci and sub are ignored outside IDLE.
- l, h and v hold stable throughout DONE regardless of out_ready.
- Reset mid-operation: RUN or DONE aborts immediately; the result is discarded and the block returns to IDLE.

## Timing
- Reset values: in_ready = 1, out_valid = 0, h = 0, l = 0, v = 0, state = IDLE, counter = 0.
- Accept at edge 0 → chunks computed at edges 1..N → out_valid high after edge N.
- Latency is N cycles from the accept edge to out_valid.
- If out_ready = 1 while out_valid = 1, DONE lasts one cycle. in_ready rises after that edge.
- Minimum initiation interval is N+2 cycles.
- CHUNK = WIDTH (N=1): RUN lasts exactly one cycle.
- The counter wraps nowhere: it is cleared on accept and compared against N-1. Its width is clog2(N), with a minimum of 1 bit.
- l, h and v are registered; they change only on entering DONE or on reset.

## Configuration
- SERIAL_ADDER_OVERFLOW_EN defined: port v exists.
  - v = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 of the internal adder operating on a and b/~b.
  - v is captured on entering DONE and is valid under the same rules as l.
- Undefined: port v and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=16, CHUNK=4, a=0xFFFF, b=0x0001, ci=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles after the accept edge; l=0x0000, h=1; in_ready=1 the cycle after.
- a=0x1234, b=0x1235, ci=0, sub=1 -> l=0xFFFF, h=1; with ci=1 and a=0x0005, b=0x0002 -> l=0x0002, h=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> l, h and out_valid=1 stable, in_ready=0, and a new in_valid is ignored; out_ready=1 -> IDLE next cycle.
- Assert rst asynchronously after 2 RUN chunks -> immediately out_valid=0, l=0, h=0, in_ready=1; next op a=0x0003, b=0x0004, ci=1 -> l=0x0008, h=0.
- With SERIAL_ADDER_OVERFLOW_EN:
  - a=0x7FFF + b=0x0001 -> l=0x8000, h=0, v=1.
  - a=0x8000 − b=0x0001 (sub=1) -> l=0x7FFF, h=0, v=1.
  - a=0x0002 + b=0x0003 -> v=0.
- WIDTH=8, CHUNK=8: a=0xAA, b=0x55, ci=1 -> l=0x00, h=1, out_valid one cycle after accept.
